// File: rtl/adder_pkg.sv
// Shared definitions for the adder stream pipeline: op encoding, parameter limits,
// lane result record and the signed-overflow predicate.
// Latency: n/a (declarations only). Backpressure: n/a.
package adder_pkg;

  // Per-lane operation encoding carried on din_op.
  localparam logic ADD_OP = 1'b0;
  localparam logic SUB_OP = 1'b1;

  // Legal parameter ranges for adder_stream_pipe.
  localparam int W_MIN      = 8;
  localparam int W_MAX      = 128;
  localparam int LANES_MAX  = 8;
  localparam int STAGES_MAX = 4;

  // One lane's result; data is sized for the widest legal lane, narrower lanes
  // occupy the low W bits.
  typedef struct packed {
    logic [W_MAX-1:0] data;
    logic             ovf;
  } lane_res_t;

  // Two's complement overflow: operands' signs are "compatible" for the op
  // (equal for add, different for sub) and the result sign differs from a.
  function automatic logic ovf_detect(input logic op, input logic sign_a,
                                      input logic sign_b, input logic sign_r);
    logic compat;
    compat = (op == SUB_OP) ? (sign_a != sign_b) : (sign_a == sign_b);
    return compat && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/adder_lane.sv
// One lane's combinational add/sub with signed overflow detect; optional clamp.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: a_i/b_i operands, op_i (0 add, 1 sub), res_o result, ovf_o signed overflow.
// Build option: ADDER_STREAM_SAT_EN clamps overflowed results to the signed range.
module adder_lane
  import adder_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         op_i,
  output logic [W-1:0] res_o,
  output logic         ovf_o
);

  logic [W-1:0] raw;

  always_comb begin
    raw   = (op_i == SUB_OP) ? (a_i - b_i) : (a_i + b_i);
    ovf_o = ovf_detect(op_i, a_i[W-1], b_i[W-1], raw[W-1]);
    res_o = raw;
`ifdef ADDER_STREAM_SAT_EN
    // Overflow can only go away from a's sign, so a's sign picks the rail:
    // negative a means the true result fell below the minimum.
    if (ovf_o) begin
      res_o = a_i[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

endmodule

// File: rtl/adder_stream_pipe.sv
// LANES-wide add/sub stream through an elastic STAGES-deep valid/ready pipeline.
// Latency: STAGES cycles input transfer to dout_tvalid; 1 beat/cycle throughput.
// Backpressure: combinational ready chain; din_tready falls only when every stage is full and stalled.
// Ports: clk, rst_n (async, active-low); din/din_op/din_tvalid/din_tready input beat;
//        dout/dout_ovf/dout_tvalid/dout_tready output beat. Lane k: a=din[2kW+:W],
//        b=din[(2k+1)W+:W], result dout[kW+:W].
// Build option: ADDER_STREAM_SAT_EN (saturating lanes, see adder_lane).
module adder_stream_pipe
  import adder_pkg::*;
#(
  parameter int W      = 64,
  parameter int LANES  = 2,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2*W*LANES-1:0]   din,
  input  logic [LANES-1:0]       din_op,
  input  logic                   din_tvalid,
  output logic                   din_tready,
  output logic [W*LANES-1:0]     dout,
  output logic [LANES-1:0]       dout_ovf,
  output logic                   dout_tvalid,
  input  logic                   dout_tready
);

  localparam int DW = W * LANES;

  logic [DW-1:0]    lane_res;
  logic [LANES-1:0] lane_ovf;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    adder_lane #(.W(W)) u_lane (
      .a_i   (din[2*k*W +: W]),
      .b_i   (din[(2*k+1)*W +: W]),
      .op_i  (din_op[k]),
      .res_o (lane_res[k*W +: W]),
      .ovf_o (lane_ovf[k])
    );
  end

  logic [STAGES-1:0] v_q, v_d, rdy;
  logic [DW-1:0]     d_q [STAGES];
  logic [DW-1:0]     d_d [STAGES];
  logic [LANES-1:0]  f_q [STAGES];
  logic [LANES-1:0]  f_d [STAGES];

  // Ready ripples back from the output: a stage can take a beat if it is empty
  // or its occupant moves on this cycle.
  always_comb begin
    rdy = '0;
    rdy[STAGES-1] = !v_q[STAGES-1] || dout_tready;
    for (int s = STAGES - 2; s >= 0; s--) begin
      rdy[s] = !v_q[s] || rdy[s+1];
    end
  end

  assign din_tready = rdy[0];

  // Empty stages are kept at zero so the outputs read 0 whenever invalid.
  always_comb begin
    v_d = v_q;
    for (int s = 0; s < STAGES; s++) begin
      d_d[s] = d_q[s];
      f_d[s] = f_q[s];
    end

    if (rdy[0]) begin
      v_d[0] = din_tvalid;
      d_d[0] = din_tvalid ? lane_res : '0;
      f_d[0] = din_tvalid ? lane_ovf : '0;
    end

    for (int s = 1; s < STAGES; s++) begin
      if (rdy[s]) begin
        v_d[s] = v_q[s-1];
        d_d[s] = v_q[s-1] ? d_q[s-1] : '0;
        f_d[s] = v_q[s-1] ? f_q[s-1] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        d_q[s] <= '0;
        f_q[s] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int s = 0; s < STAGES; s++) begin
        d_q[s] <= d_d[s];
        f_q[s] <= f_d[s];
      end
    end
  end

  assign dout        = d_q[STAGES-1];
  assign dout_ovf    = f_q[STAGES-1];
  assign dout_tvalid = v_q[STAGES-1];

endmodule

// File: tb/tb_adder_stream_pipe.sv
// Directed bench for adder_stream_pipe: main instance STAGES=2 plus STAGES=1/4
// instances sharing the same input stream for latency and reset checks.
module tb_adder_stream_pipe;
  import adder_pkg::*;

  localparam int W     = 64;
  localparam int LANES = 2;

  localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  logic [2*W*LANES-1:0] din;
  logic [LANES-1:0]     din_op;
  logic                 din_tvalid;
  logic                 dout_tready;

  logic                 din_tready, din_tready1, din_tready4;
  logic [W*LANES-1:0]   dout, dout1, dout4;
  logic [LANES-1:0]     dout_ovf, dout_ovf1, dout_ovf4;
  logic                 dout_tvalid, dout_tvalid1, dout_tvalid4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_stream_pipe #(.W(W), .LANES(LANES), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_op(din_op), .din_tvalid(din_tvalid),
    .din_tready(din_tready), .dout(dout), .dout_ovf(dout_ovf),
    .dout_tvalid(dout_tvalid), .dout_tready(dout_tready)
  );

  adder_stream_pipe #(.W(W), .LANES(LANES), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_op(din_op), .din_tvalid(din_tvalid),
    .din_tready(din_tready1), .dout(dout1), .dout_ovf(dout_ovf1),
    .dout_tvalid(dout_tvalid1), .dout_tready(dout_tready)
  );

  adder_stream_pipe #(.W(W), .LANES(LANES), .STAGES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_op(din_op), .din_tvalid(din_tvalid),
    .din_tready(din_tready4), .dout(dout4), .dout_ovf(dout_ovf4),
    .dout_tvalid(dout_tvalid4), .dout_tready(dout_tready)
  );

  task automatic set_beat(input logic [W-1:0] a0, input logic [W-1:0] b0, input logic op0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1, input logic op1);
    din    = {b1, a1, b0, a0};
    din_op = {op1, op0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic lane_res_t mk(input logic [W-1:0] d, input logic o);
    lane_res_t r;
    r = '0;
    r.data[W-1:0] = d;
    r.ovf = o;
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    din_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 8; i++) din[i*32 +: 32] = $urandom;
      din_op = LANES'($urandom);
      dout_tready = 1'($urandom);
      tick();
      checks++;
      if ({dout, dout_ovf, dout_tvalid} !== '0) begin
        errors++;
        $display("FAIL reset_idle: dout=%h ovf=%b vld=%b, want all 0", dout, dout_ovf, dout_tvalid);
      end
    end
    din_tvalid = 1'b0;
    dout_tready = 1'b1;
    rst_n = 1'b1;
    tick();
    set_beat(64'd1, 64'd2, ADD_OP, 64'd9, 64'd4, SUB_OP);
    din_tvalid = 1'b1;
    #1;
    checks++;
    if (din_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: din_tready=%b, want 1", din_tready);
    end
    tick();
    din_tvalid = 1'b0;
    checks++;
    if (dout_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_lat_early: dout_tvalid=%b one cycle after transfer, want 0", dout_tvalid);
    end
    tick();
    checks++;
    if (dout_tvalid !== 1'b1 || dout !== {64'd5, 64'd3} || dout_ovf !== 2'b00) begin
      errors++;
      $display("FAIL reset_first_beat: vld=%b dout=%h ovf=%b, want 1 %h 00",
               dout_tvalid, dout, dout_ovf, {64'd5, 64'd3});
    end
    tick();
    checks++;
    if (dout_tvalid !== 1'b0 || dout !== '0 || dout_ovf !== '0) begin
      errors++;
      $display("FAIL reset_drain: vld=%b dout=%h ovf=%b, want 0 0 0", dout_tvalid, dout, dout_ovf);
    end
  endtask

  task automatic test_streaming();
    int got = 0, first = -1, last = -1, rdy_low = 0;
    dout_tready = 1'b1;
    set_beat(64'd5, 64'd7, ADD_OP, 64'd10, 64'd3, SUB_OP);
    for (int c = 0; c < 104; c++) begin
      din_tvalid = (c < 100);
      #1;
      if (din_tvalid && !din_tready) rdy_low++;
      tick();
      if (dout_tvalid) begin
        checks++;
        if (dout !== {64'd7, 64'd12} || dout_ovf !== 2'b00) begin
          errors++;
          $display("FAIL stream_data[%0d]: dout=%h ovf=%b, want %h 00", got, dout, dout_ovf,
                   {64'd7, 64'd12});
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    din_tvalid = 1'b0;
    checks++;
    if (got !== 100) begin
      errors++;
      $display("FAIL stream_count: got %0d beats, want 100", got);
    end
    checks++;
    if (first !== 1 || last !== 100) begin
      errors++;
      $display("FAIL stream_b2b: first=%0d last=%0d, want 1 100", first, last);
    end
    checks++;
    if (rdy_low !== 0) begin
      errors++;
      $display("FAIL stream_ready: din_tready low %0d cycles, want 0", rdy_low);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] a0 [4], b0 [4], a1 [4], b1 [4];
    logic         o0 [4], o1 [4];
    lane_res_t    e0 [4], e1 [4];
    int n = 0;
    a0[0] = MAXP;  b0[0] = 64'd1; o0[0] = ADD_OP; a1[0] = 64'd0; b1[0] = 64'd1; o1[0] = SUB_OP;
    a0[1] = MINN;  b0[1] = 64'd1; o0[1] = SUB_OP; a1[1] = MINN;  b1[1] = MINN;  o1[1] = ADD_OP;
    a0[2] = MAXP;  b0[2] = ONES;  o0[2] = SUB_OP; a1[2] = ONES;  b1[2] = 64'd1; o1[2] = SUB_OP;
    a0[3] = 64'd3; b0[3] = 64'd3; o0[3] = SUB_OP; a1[3] = 64'd2; b1[3] = 64'd3; o1[3] = ADD_OP;
`ifdef ADDER_STREAM_SAT_EN
    e0[0] = mk(MAXP, 1'b1); e1[0] = mk(ONES, 1'b0);
    e0[1] = mk(MINN, 1'b1); e1[1] = mk(MINN, 1'b1);
    e0[2] = mk(MAXP, 1'b1); e1[2] = mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
`else
    e0[0] = mk(MINN, 1'b1); e1[0] = mk(ONES, 1'b0);
    e0[1] = mk(MAXP, 1'b1); e1[1] = mk(64'd0, 1'b1);
    e0[2] = mk(MINN, 1'b1); e1[2] = mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
`endif
    e0[3] = mk(64'd0, 1'b0); e1[3] = mk(64'd5, 1'b0);
    dout_tready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      din_tvalid = (c < 4);
      if (c < 4) set_beat(a0[c], b0[c], o0[c], a1[c], b1[c], o1[c]);
      #1;
      tick();
      if (dout_tvalid && n < 4) begin
        checks++;
        if (dout[0 +: W] !== e0[n].data[W-1:0] || dout_ovf[0] !== e0[n].ovf ||
            dout[W +: W] !== e1[n].data[W-1:0] || dout_ovf[1] !== e1[n].ovf) begin
          errors++;
          $display("FAIL ovf_beat[%0d]: l0=%h/%b l1=%h/%b, want l0=%h/%b l1=%h/%b", n,
                   dout[0 +: W], dout_ovf[0], dout[W +: W], dout_ovf[1],
                   e0[n].data[W-1:0], e0[n].ovf, e1[n].data[W-1:0], e1[n].ovf);
        end
        n++;
      end
    end
    din_tvalid = 1'b0;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL ovf_count: got %0d beats, want 4", n);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, rcv = 0, cyc = 0;
    logic exp_rdy, in_x, out_x, stall;
    logic [W*LANES-1:0] saved;
    while (rcv < 20 && cyc < 400) begin
      din_tvalid = (sent < 20);
      set_beat(64'(sent * 3), 64'd100, ADD_OP, 64'd1000, 64'(sent), SUB_OP);
      dout_tready = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = ((sent - rcv) < 2) || dout_tready;
      checks++;
      if (din_tready !== exp_rdy) begin
        errors++;
        $display("FAIL bp_ready[cyc %0d]: din_tready=%b, want %b", cyc, din_tready, exp_rdy);
      end
      in_x  = din_tvalid && din_tready;
      out_x = dout_tvalid && dout_tready;
      stall = dout_tvalid && !dout_tready;
      saved = dout;
      if (out_x) begin
        checks++;
        if (dout !== {64'(1000 - rcv), 64'(rcv * 3 + 100)} || dout_ovf !== 2'b00) begin
          errors++;
          $display("FAIL bp_data[%0d]: dout=%h ovf=%b, want %h 00", rcv, dout, dout_ovf,
                   {64'(1000 - rcv), 64'(rcv * 3 + 100)});
        end
        rcv++;
      end
      if (in_x) sent++;
      tick();
      if (stall) begin
        checks++;
        if (dout_tvalid !== 1'b1 || dout !== saved) begin
          errors++;
          $display("FAIL bp_hold[cyc %0d]: vld=%b dout=%h, want 1 %h", cyc, dout_tvalid, dout, saved);
        end
      end
      cyc++;
    end
    din_tvalid = 1'b0;
    dout_tready = 1'b1;
    checks++;
    if (rcv !== 20) begin
      errors++;
      $display("FAIL bp_count: received %0d beats in %0d cycles, want 20", rcv, cyc);
    end
    checks++;
    if (dout_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_dup: dout_tvalid=%b after last beat, want 0", dout_tvalid);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_midreset();
    int stale = 0;
    dout_tready = 1'b1;
    din_tvalid = 1'b1;
    set_beat(64'd11, 64'd22, ADD_OP, 64'd33, 64'd44, ADD_OP);
    tick();
    set_beat(64'd55, 64'd66, ADD_OP, 64'd77, 64'd88, ADD_OP);
    tick();
    din_tvalid = 1'b0;
    checks++;
    if (dout_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL mrst_pre: dout_tvalid=%b with beats in flight, want 1", dout_tvalid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout_tvalid !== 1'b0 || dout !== '0 || dout_ovf !== '0) begin
      errors++;
      $display("FAIL mrst_async: vld=%b dout=%h ovf=%b right after reset, want 0 0 0",
               dout_tvalid, dout, dout_ovf);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (dout_tvalid || dout_tvalid1 || dout_tvalid4) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL mrst_stale: %0d cycles with a stale beat, want 0", stale);
    end
  endtask

  task automatic test_latency();
    int lat1 = 0, lat2 = 0, lat4 = 0;
    logic [W*LANES-1:0] exp_d;
    exp_d = {64'd42, 64'd42};
    dout_tready = 1'b1;
    din_tvalid = 1'b1;
    set_beat(64'd20, 64'd22, ADD_OP, 64'd50, 64'd8, SUB_OP);
    #1;
    tick();
    din_tvalid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (dout_tvalid1 && lat1 == 0) begin
        lat1 = c;
        checks++;
        if (dout1 !== exp_d) begin
          errors++;
          $display("FAIL lat_data_s1: dout=%h, want %h", dout1, exp_d);
        end
      end
      if (dout_tvalid && lat2 == 0) lat2 = c;
      if (dout_tvalid4 && lat4 == 0) begin
        lat4 = c;
        checks++;
        if (dout4 !== exp_d) begin
          errors++;
          $display("FAIL lat_data_s4: dout=%h, want %h", dout4, exp_d);
        end
      end
      tick();
    end
    checks++;
    if (lat1 !== 1) begin
      errors++;
      $display("FAIL lat_s1: latency %0d, want 1", lat1);
    end
    checks++;
    if (lat2 !== 2) begin
      errors++;
      $display("FAIL lat_s2: latency %0d, want 2", lat2);
    end
    checks++;
    if (lat4 !== 4) begin
      errors++;
      $display("FAIL lat_s4: latency %0d, want 4", lat4);
    end
  endtask

  initial begin
    din = '0;
    din_op = '0;
    din_tvalid = 1'b0;
    dout_tready = 1'b0;
    rst_n = 1'b0;
    #2;
    test_reset();
    test_streaming();
    test_overflow();
    test_backpressure();
    test_midreset();
    test_latency();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
